// File: rtl/dtree_pkg.sv
// Shared types and geometry for the sequential decision-tree engine.
// The tree geometry lives here so the node word layout is defined in one place.
package dtree_pkg;

  localparam int N_FEAT    = 561;
  localparam int FEAT_W    = 8;
  localparam int CLASS_W   = 3;
  localparam int N_NODES   = 256;
  localparam int MAX_DEPTH = 32;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int node_w(input int n_feat, input int feat_w, input int n_nodes);
    return 1 + addr_w(n_feat) + feat_w + 2 * addr_w(n_nodes);
  endfunction

  localparam int FI_W   = addr_w(N_FEAT);
  localparam int AW     = addr_w(N_NODES);
  localparam int NODE_W = node_w(N_FEAT, FEAT_W, N_NODES);
  localparam int DW     = $clog2(MAX_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } state_e;

  // Leaf nodes reuse the threshold field to carry the class label.
  typedef struct packed {
    logic              leaf;
    logic [FI_W-1:0]   feat_idx;
    logic [FEAT_W-1:0] thr;
    logic [AW-1:0]     left;
    logic [AW-1:0]     right;
  } node_t;

  function automatic logic [CLASS_W-1:0] leaf_class(input node_t n);
    return n.thr[CLASS_W-1:0];
  endfunction

endpackage

// File: rtl/dtree_node_table.sv
// Register-array node store: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; software programs the tree after power-up.
module dtree_node_table
  import dtree_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  node_t         wdata,
  input  logic [AW-1:0] raddr,
  output node_t         rdata
);

  node_t mem_q [N_NODES];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dtree_seq_engine.sv
// Table-driven decision-tree classifier: walks one node per cycle over a latched vector.
// Optional DTREE_CYCLE_CNT_EN adds out_depth (path length) and out_count (handshake count).
module dtree_seq_engine
  import dtree_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_FEAT*FEAT_W-1:0] in_feat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CLASS_W-1:0]       out_class,
  output logic                     out_err,
  input  logic                     cfg_we,
  input  logic [AW-1:0]            cfg_addr,
  input  logic [NODE_W-1:0]        cfg_wdata,
  output logic                     cfg_err
`ifdef DTREE_CYCLE_CNT_EN
  ,
  output logic [DW-1:0]            out_depth,
  output logic [31:0]              out_count
`endif
);

  // When the node table fills the whole pointer space no child can be out of range.
  localparam bit PTR_FULL = (N_NODES == (1 << AW));

  state_e                         state_q, state_d;
  logic [N_FEAT-1:0][FEAT_W-1:0]  feat_q, feat_d;
  logic [AW-1:0]                  ptr_q, ptr_d;
  logic [DW-1:0]                  depth_q, depth_d;
  logic                           out_valid_q, out_valid_d;
  logic [CLASS_W-1:0]             class_q, class_d;
  logic                           err_q, err_d;
  logic                           cfg_err_q, cfg_err_d;
  logic                           table_we;
  logic                           bad_ptr;
  logic [FEAT_W-1:0]              feat_sel;
  node_t                          nd;

  dtree_node_table u_table (
    .clk   (clk),
    .we    (table_we),
    .waddr (cfg_addr),
    .wdata (node_t'(cfg_wdata)),
    .raddr (ptr_q),
    .rdata (nd)
  );

  always_comb begin
    state_d     = state_q;
    feat_d      = feat_q;
    ptr_d       = ptr_q;
    depth_d     = depth_q;
    out_valid_d = out_valid_q;
    class_d     = class_q;
    err_d       = err_q;
    table_we    = cfg_we && (state_q == IDLE);
    cfg_err_d   = cfg_err_q || (cfg_we && (state_q != IDLE));
    bad_ptr     = !PTR_FULL && (int'(ptr_q) >= N_NODES);
    feat_sel    = feat_q[nd.feat_idx];

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          feat_d  = in_feat;
          ptr_d   = '0;
          depth_d = '0;
          state_d = WALK;
        end
      end
      WALK: begin
        if (!bad_ptr && nd.leaf) begin
          class_d = leaf_class(nd);
          err_d   = 1'b0;
          state_d = DONE;
        end else if (bad_ptr || int'(nd.feat_idx) >= N_FEAT ||
                     int'(depth_q) == MAX_DEPTH - 1) begin
          class_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          ptr_d   = (feat_sel <= nd.thr) ? nd.left : nd.right;
          depth_d = depth_q + 1'b1;
        end
      end
      DONE: begin
        // out_valid rises one cycle after entering DONE and holds until taken.
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      depth_q     <= '0;
      out_valid_q <= 1'b0;
      class_q     <= '0;
      err_q       <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      depth_q     <= depth_d;
      out_valid_q <= out_valid_d;
      class_q     <= class_d;
      err_q       <= err_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // The latched vector is only meaningful during a walk, so it needs no reset.
  always_ff @(posedge clk) begin
    feat_q <= feat_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_class = class_q;
  assign out_err   = err_q;
  assign cfg_err   = cfg_err_q;

`ifdef DTREE_CYCLE_CNT_EN
  logic [DW-1:0] odepth_q, odepth_d;
  logic [31:0]   count_q, count_d;

  always_comb begin
    odepth_d = odepth_q;
    count_d  = count_q;
    if (state_q == WALK && state_d == DONE) odepth_d = depth_q;
    if (out_valid_q && out_ready && count_q != 32'hFFFF_FFFF) count_d = count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      odepth_q <= '0;
      count_q  <= '0;
    end else begin
      odepth_q <= odepth_d;
      count_q  <= count_d;
    end
  end

  assign out_depth = odepth_q;
  assign out_count = count_q;
`endif

endmodule
